serial_rx_port: RTL
===================

Name: serial_rx_port

Overview:
Memory-mapped serial receiver for the 8-bit CPU. It is the receive end of the CPU's bit-banged serial line: idle high, 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), each bit CLKS_PER_BIT clocks long. It deframes incoming bytes into a data register and raises a ready flag. The CPU polls status and reads data through two fixed addresses on its 8-bit address bus.

Parameters:
CLKS_PER_BIT, 16, clocks per serial bit; legal range ≥4, even values only.
DATA_ADDR, 8'hFE, read address of the received-data register.
STATUS_ADDR, 8'hFD, read address of the status register.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
nclear  input  1  asynchronous active-low reset; clears all state.
serial_in  input  1  asynchronous serial line, idle high.
addr  input  8  CPU address bus.
rd  input  1  CPU read strobe, sampled on the rising clock edge.
rd_data  output  8  combinational read data; 8'h00 when addr matches neither address.
ready  output  1  mirror of status bit0, for polling or interrupts.

Behaviour:
- Reset (nclear=0, asynchronous): FSM=IDLE, counters=0, data register=8'h00, all status bits=0, ready=0. Synchronizer flops preset to 1, so no false start occurs on release.
- serial_in passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s. This adds 2 clocks of input latency.
- Status byte: bit0 READY, bit1 OVERRUN, bit2 FRAMING_ERR, bit3 PARITY_ERR (see the optional feature), bits7:4 = 0.
- IDLE: when rx_s=0, go to START and load bit counter = CLKS_PER_BIT/2 − 1.
- START: at count 0, resample. If rx_s=1, it was a false start: return to IDLE. Otherwise go to DATA with bit index=0 and counter=CLKS_PER_BIT−1.
- DATA: at each count 0, shift rx_s into bit[index] (LSB first) and reload the counter. After index 7, go to PARITY (if enabled) or STOP.
- STOP: at count 0, sample rx_s.
  - If rx_s=1: load the data register with the shifted byte and set READY. If READY was already 1, also set OVERRUN; the new byte overwrites the old one. Then go to IDLE.
  - If rx_s=0: set FRAMING_ERR, leave the data register and READY unchanged, and go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- READY rises on the clock edge after the stop-bit mid-sample. Total latency from the start-bit falling edge is 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT clocks (no parity).
- Read side effects, on the rising edge with rd=1:
  - addr=DATA_ADDR clears READY and OVERRUN.
  - addr=STATUS_ADDR clears FRAMING_ERR and PARITY_ERR.
  - rd_data is combinational from the registers as they stand before the edge.
- Simultaneous events: a byte completing on the same edge as a DATA_ADDR read loads the new byte, and READY stays 1 with OVERRUN=0 (the read consumed the old byte). An error set on the same edge as a STATUS_ADDR read wins: the error bit stays 1.
- rd with a non-matching addr has no effect.

Optional Feature:
SERIAL_RX_PARITY_EN
- Defined: a PARITY state follows DATA and samples one even-parity bit. A mismatch sets PARITY_ERR, but the byte is still loaded if the stop bit is valid. Frame length is 11 bits.
- Undefined: no PARITY state, PARITY_ERR is tied to 0, and the frame is 10 bits.

Decomposition:
- Package serial_rx_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - status bit index constants (ST_READY=0, ST_OVR=1, ST_FERR=2, ST_PERR=3);
  - default addresses.
- One sub-module, sync_2ff: a 2-flop synchronizer with a parameterized reset value, reused for other asynchronous inputs.

Test Plan:
- Frame 0xA5, CLKS_PER_BIT=16 → ready=1 at the stated latency. Reading FE returns 8'hA5, and ready=0 on the next cycle.
- 4-clock low glitch on an idle line → FSM returns to IDLE, ready stays 0, status reads 8'h00.
- Frame 0x3C with the stop bit held low for 20 bit times → status reads 8'h04 and the data register is unchanged. After the line returns high, a 0x11 frame is received correctly.
- Frames 0x12 then 0x34 with no read in between → status reads 8'h03 and FE returns 8'h34. After that read, status reads 8'h00.
- nclear pulsed low at data bit 4 of a frame → rd_data at FD/FE is 8'h00 and ready=0 immediately (asynchronous). The next full frame 0x5A is received correctly.
- With SERIAL_RX_PARITY_EN: frame 0x07 sent with parity bit 0 (wrong; correct is 1) → status reads 8'h09 and FE returns 8'h07.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the memory-mapped serial receiver.
// Parity support is selected with SERIAL_RX_PARITY_EN.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int ST_READY = 0;
  localparam int ST_OVR   = 1;
  localparam int ST_FERR  = 2;
  localparam int ST_PERR  = 3;

  localparam logic [7:0] DEF_DATA_ADDR   = 8'hFE;
  localparam logic [7:0] DEF_STATUS_ADDR = 8'hFD;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input.
// RESET_VAL picks the level both flops hold during reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_port.sv
// CPU-polled serial receiver: 8N1 deframer with data/status registers.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit after the data.
module serial_rx_port
  import serial_rx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] DATA_ADDR    = DEF_DATA_ADDR,
  parameter logic [7:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
  input  logic       clock,
  input  logic       nclear,
  input  logic       serial_in,
  input  logic [7:0] addr,
  input  logic       rd,
  output logic [7:0] rd_data,
  output logic       ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [7:0]    data_q;
  logic          rdy;
  logic          ovr;
  logic          ferr;
  logic          perr;
  logic          rx_s;
  logic [7:0]    status;

  logic tick;
  logic load;
  logic ferr_set;
  logic rd_dat;
  logic rd_st;

  // Idle-high line: presetting the synchronizer avoids a false start.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clock),
    .rst_n(nclear),
    .d    (serial_in),
    .q    (rx_s)
  );

  assign tick     = (cnt == '0);
  assign load     = (state == STOP) && tick && rx_s;
  assign ferr_set = (state == STOP) && tick && !rx_s;
  assign rd_dat   = rd && (addr == DATA_ADDR);
  assign rd_st    = rd && (addr == STATUS_ADDR);

  always_ff @(posedge clock or negedge nclear) begin
    if (!nclear) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF;
          end
        end
        START: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            state <= DATA;
            idx   <= '0;
            cnt   <= FULL;
          end
        end
        DATA: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg[idx] <= rx_s;
            idx        <= idx + 1'b1;
            cnt        <= FULL;
            if (idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt   <= FULL;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= rx_s ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A data read on the completing edge consumes the old byte, so
  // overrun only latches when READY survives the read.
  always_ff @(posedge clock or negedge nclear) begin
    if (!nclear) begin
      data_q <= 8'h00;
      rdy    <= 1'b0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (load) begin
        data_q <= shreg;
        rdy    <= 1'b1;
        ovr    <= (ovr && !rd_dat) || (rdy && !rd_dat);
      end else if (rd_dat) begin
        rdy <= 1'b0;
        ovr <= 1'b0;
      end
      if (ferr_set) begin
        ferr <= 1'b1;
      end else if (rd_st) begin
        ferr <= 1'b0;
      end
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  logic perr_set;

  assign perr_set = (state == PARITY) && tick && (rx_s != ^shreg);

  always_ff @(posedge clock or negedge nclear) begin
    if (!nclear) begin
      perr <= 1'b0;
    end else if (perr_set) begin
      perr <= 1'b1;
    end else if (rd_st) begin
      perr <= 1'b0;
    end
  end
`else
  assign perr = 1'b0;
`endif

  always_comb begin
    status           = 8'h00;
    status[ST_READY] = rdy;
    status[ST_OVR]   = ovr;
    status[ST_FERR]  = ferr;
    status[ST_PERR]  = perr;
  end

  always_comb begin
    rd_data = 8'h00;
    if (addr == DATA_ADDR) begin
      rd_data = data_q;
    end else if (addr == STATUS_ADDR) begin
      rd_data = status;
    end
  end

  assign ready = rdy;

endmodule
